// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder.
// Operands are captured on an accepted start and shifted out LSB-first
// through a full-adder slice built from two half adders and an OR gate.
// A registered carry links consecutive bits, and the sum is reassembled
// MSB-first into a parallel word.
//
// Optional feature macro: SERIAL_ADDER_OVF_EN adds a registered ovf port
// (two's-complement signed overflow of the addition).
//
// Ports:
//   clk    - clock, rising edge
//   rst_n  - asynchronous active-low reset
//   start  - request, sampled only when not busy
//   a, b   - operands (WIDTH bits), captured on accepted start
//   cin    - carry-in, captured on accepted start
//   busy   - high while bits are being shifted
//   done   - one-cycle pulse when sum/cout are valid
//   sum    - result word, held until the next accepted start
//   cout   - final carry-out, held with sum
//   ovf    - signed overflow, held with sum (SERIAL_ADDER_OVF_EN only)
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADDER_OVF_EN
  output logic             ovf,
`endif
  output logic             cout
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic ha1_s, ha1_c, ha2_s, ha2_c, carry_nx;
  logic accept, last_bit;

  // Full-adder slice: two half adders plus an OR for the carry
  always_comb begin
    ha1_s    = op_a_q[0] ^ op_b_q[0];
    ha1_c    = op_a_q[0] & op_b_q[0];
    ha2_s    = ha1_s ^ carry_q;
    ha2_c    = ha1_s & carry_q;
    carry_nx = ha1_c | ha2_c;
  end

  assign accept   = start && (state_q != SHIFT);
  assign last_bit = (cnt_q == CW'(WIDTH - 1));

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif

    case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          state_d = SHIFT;
          op_a_d  = a;
          op_b_d  = b;
          carry_d = cin;
          cnt_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
          ovf_d   = 1'b0;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        sum_d   = {ha2_s, sum_q[WIDTH-1:1]};
        op_a_d  = {1'b0, op_a_q[WIDTH-1:1]};
        op_b_d  = {1'b0, op_b_q[WIDTH-1:1]};
        carry_d = carry_nx;
        cnt_d   = cnt_q + CW'(1);
        if (last_bit) begin
          state_d = DONE;
          cout_d  = carry_nx;
`ifdef SERIAL_ADDER_OVF_EN
          // carry_q here is the carry into the MSB
          ovf_d   = carry_q ^ carry_nx;
`endif
        end
      end
      default: state_d = IDLE;
    endcase

    // Flags follow the next state so they are valid in the same cycle
    busy_d = (state_d == SHIFT);
    done_d = (state_d == DONE);
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_a_q  <= '0;
      op_b_q  <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Testbench for serial_adder (WIDTH=8): table-driven vectors plus
// hand-written multi-cycle sequences, with a queue scoreboard.
module tb_serial_adder;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a, b;
  logic         cin;
  logic         busy, done, cout;
  logic [W-1:0] sum;
`ifdef SERIAL_ADDER_OVF_EN
  logic         ovf;
`endif

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
`ifdef SERIAL_ADDER_OVF_EN
    .ovf   (ovf),
`endif
    .cout  (cout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] s;
    logic         c;
    logic         o;
  } exp_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] s;
    logic         c;
    logic         o;
  } vec_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  // Drive one start pulse; returns in cycle k+1 with start low
  task automatic launch(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                        input logic tc, input exp_t e);
    @(negedge clk);
    a = ta; b = tb_v; cin = tc; start = 1'b1;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Bounded wait for done; cyc is the cycle index relative to the accepting edge
  task automatic wait_done(input int cyc0, output int cyc, output int bcnt);
    cyc  = cyc0;
    bcnt = 0;
    while (!done && cyc < 40) begin
      if (busy) bcnt++;
      @(negedge clk);
      cyc++;
    end
  endtask

  // Called in the done cycle: pop the expectation and compare
  task automatic check_result(input string nm);
    exp_t e;
    chk({nm, " done"}, 32'(done), 32'd1);
    chk({nm, " busy_in_done"}, 32'(busy), 32'd0);
    if (sb.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: got done with empty scoreboard, required pending result", nm);
    end else begin
      e = sb.pop_front();
      chk({nm, " sum"}, 32'(sum), 32'(e.s));
      chk({nm, " cout"}, 32'(cout), 32'(e.c));
`ifdef SERIAL_ADDER_OVF_EN
      chk({nm, " ovf"}, 32'(ovf), 32'(e.o));
`endif
    end
    @(negedge clk);
    chk({nm, " done_pulse_len"}, 32'(done), 32'd0);
  endtask

  function automatic int count_done_over(input int n);
    return n;
  endfunction

  vec_t vecs[8];
  int   cyc, bcnt, ndone;

  initial begin
    vecs[0] = '{a:8'h0F, b:8'h01, cin:1'b0, s:8'h10, c:1'b0, o:1'b0};
    vecs[1] = '{a:8'hFF, b:8'h01, cin:1'b0, s:8'h00, c:1'b1, o:1'b0};
    vecs[2] = '{a:8'hFF, b:8'hFF, cin:1'b1, s:8'hFF, c:1'b1, o:1'b0};
    vecs[3] = '{a:8'h7F, b:8'h01, cin:1'b0, s:8'h80, c:1'b0, o:1'b1};
    vecs[4] = '{a:8'h80, b:8'hFF, cin:1'b0, s:8'h7F, c:1'b1, o:1'b1};
    vecs[5] = '{a:8'h05, b:8'h03, cin:1'b0, s:8'h08, c:1'b0, o:1'b0};
    vecs[6] = '{a:8'hAA, b:8'h55, cin:1'b1, s:8'h00, c:1'b1, o:1'b0};
    vecs[7] = '{a:8'h00, b:8'h00, cin:1'b0, s:8'h00, c:1'b0, o:1'b0};

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset sum", 32'(sum), 32'd0);
    chk("reset cout", 32'(cout), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
    chk("reset ovf", 32'(ovf), 32'd0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven single operations
    for (int i = 0; i < 8; i++) begin
      launch(vecs[i].a, vecs[i].b, vecs[i].cin,
             '{s:vecs[i].s, c:vecs[i].c, o:vecs[i].o});
      wait_done(1, cyc, bcnt);
      chk($sformatf("vec%0d latency", i), 32'(cyc), 32'd9);
      chk($sformatf("vec%0d busy_cycles", i), 32'(bcnt), 32'd8);
      check_result($sformatf("vec%0d", i));
    end

    // Start re-pulsed while busy is ignored
    launch(8'h01, 8'h01, 1'b0, '{s:8'h02, c:1'b0, o:1'b0});
    @(negedge clk);                 // k+2
    @(negedge clk);                 // k+3
    a = 8'hAA; start = 1'b1;
    @(negedge clk);                 // k+4
    start = 1'b0;
    wait_done(4, cyc, bcnt);
    chk("ignore latency", 32'(cyc), 32'd9);
    check_result("ignore");
    ndone = 0;
    repeat (12) begin
      if (done) ndone++;
      @(negedge clk);
    end
    chk("ignore extra_done", 32'(ndone), 32'd0);

    // Asynchronous reset mid-shift discards the operation
    launch(8'h0F, 8'h0F, 1'b0, '{s:8'h1E, c:1'b0, o:1'b0});
    chk("rst_mid busy_before", 32'(busy), 32'd1);
    @(negedge clk);                 // k+2
    @(negedge clk);                 // k+3
    @(negedge clk);                 // k+4
    rst_n = 1'b0;
    #1;
    chk("rst_mid busy", 32'(busy), 32'd0);
    chk("rst_mid done", 32'(done), 32'd0);
    chk("rst_mid sum", 32'(sum), 32'd0);
    chk("rst_mid cout", 32'(cout), 32'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    repeat (15) begin
      if (done) ndone++;
      @(negedge clk);
    end
    chk("rst_mid no_done", 32'(ndone), 32'd0);
    launch(8'h0F, 8'h0F, 1'b0, '{s:8'h1E, c:1'b0, o:1'b0});
    wait_done(1, cyc, bcnt);
    chk("rst_fresh latency", 32'(cyc), 32'd9);
    check_result("rst_fresh");

    // Start held high: back-to-back operations
    @(negedge clk);
    a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
    sb.push_back('{s:8'h30, c:1'b0, o:1'b0});
    @(negedge clk);                 // k+1
    a = 8'h01; b = 8'h02;
    sb.push_back('{s:8'h03, c:1'b0, o:1'b0});
    wait_done(1, cyc, bcnt);
    chk("b2b first latency", 32'(cyc), 32'd9);
    check_result("b2b first");      // returns in cycle k+10
    start = 1'b0;
    chk("b2b busy_after_reaccept", 32'(busy), 32'd1);
    wait_done(10, cyc, bcnt);
    chk("b2b second latency", 32'(cyc), 32'd18);
    check_result("b2b second");
    chk("b2b scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial N-bit adder. Two parallel operands are loaded, then shifted out LSB-first through a full-adder slice built from two half adders plus an OR gate. A registered carry links consecutive bits, and the result is reassembled into a parallel word. It sits directly downstream of the half-adder primitive and is the first sequential consumer of it. It trades WIDTH cycles of latency for a single-bit datapath.

## Interface

Parameters:
- WIDTH, 8, operand and result width in bits (≥2)

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request; sampled only when busy=0
- a  input  WIDTH  operand A, captured on accepted start
- b  input  WIDTH  operand B, captured on accepted start
- cin  input  1  carry-in, captured on accepted start
- busy  output  1  high while bits are being shifted
- done  output  1  one-cycle pulse when result is valid
- sum  output  WIDTH  result word; held until next accepted start
- cout  output  1  final carry-out; held with sum

## Operation

- FSM has three states: IDLE, SHIFT, DONE. Encoding is free.
- Transitions:
  - IDLE: start=1 → SHIFT; otherwise stay.
  - SHIFT: stays for exactly WIDTH cycles, then → DONE.
  - DONE: start=1 → SHIFT (back-to-back accepted); otherwise → IDLE.
- On an accepted start:
  - opA←a, opB←b, carry flop←cin, bit counter←0.
  - sum register and cout are cleared to 0.
- Each SHIFT cycle:
  - HA1 takes (opA[0], opB[0]) and produces s1, c1.
  - HA2 takes (s1, carry) and produces s, c2.
  - Next carry is c1|c2.
  - sum register shifts right with s entering at MSB; opA and opB shift right.
  - Counter increments.
- On the last SHIFT cycle (counter=WIDTH-1), the carry result is also written to cout.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1). No truncation.
- start while busy=1 is ignored. Operand inputs are don't-care outside the accepting edge.
- Reset (asynchronous, any time, including mid-SHIFT) forces:
  - state=IDLE, busy=0, done=0, sum=0, cout=0.
  - Internal opA/opB/carry/counter=0.
  - The in-flight operation is discarded; no done pulse.

## Timing

- Reset values: busy=0, done=0, sum=0, cout=0 (ovf=0 when enabled).
- Start accepted at edge k:
  - busy=1 from cycle k+1 through k+WIDTH.
  - done=1 for exactly cycle k+WIDTH+1, with busy=0 in that cycle.
- Latency from accepting edge to done: WIDTH+1 cycles. Throughput: one add per WIDTH+1 cycles with back-to-back start.
- sum/cout are valid and stable from the done cycle until the edge after the next accepted start.
- start held high continuously → a new operation is accepted in every DONE cycle; done pulses every WIDTH+1 cycles.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration

- SERIAL_ADDER_OVF_EN defined:
  - Adds output port ovf (1 bit).
  - The carry into the MSB is captured on the last SHIFT cycle.
  - ovf = carry_into_msb XOR final carry, i.e. two's-complement signed overflow.
  - ovf is reset to 0, cleared on accepted start, and held with sum.
- SERIAL_ADDER_OVF_EN undefined: no ovf port and no extra flop; behaviour is otherwise identical.

## Test plan

All scenarios use WIDTH=8.

- a=8'h0F, b=8'h01, cin=0, start pulse at edge k → busy high for 8 cycles; done at k+9; sum=8'h10, cout=0.
- a=8'hFF, b=8'h01, cin=0 → sum=8'h00, cout=1. Then a=8'hFF, b=8'hFF, cin=1 → sum=8'hFF, cout=1.
- With SERIAL_ADDER_OVF_EN defined:
  - a=8'h7F, b=8'h01 → sum=8'h80, cout=0, ovf=1.
  - a=8'h80, b=8'hFF → sum=8'h7F, cout=1, ovf=1.
  - a=8'h05, b=8'h03 → ovf=0.
- start with a=8'h01, b=8'h01, then start re-pulsed at k+3 with a=8'hAA → second start ignored; done only at k+9; sum=8'h02.
- Start a=8'h0F, b=8'h0F; assert rst_n=0 at k+4 for one cycle → busy, done, sum, cout drop to 0 immediately; no done pulse follows. A fresh start then yields the correct result at +9 cycles.
- start held high with two operand pairs (8'h10+8'h20, then 8'h01+8'h02) → done pulses at k+9 and k+18; sum=8'h30, then 8'h03.
